// File: rtl/lsb_stego_pkg.sv
// lsb_stego_pkg: shared defaults, FSM states and terminator byte for lsb_embed
// (LSB_EMBED_TERMINATOR_EN adds the TERM state)
package lsb_stego_pkg;
   localparam int         PIXEL_W_DEF      = 16;
   localparam int         FRAME_PIXELS_DEF = 41420;
   localparam logic [7:0] TERM_BYTE        = 8'h00;
`ifdef LSB_EMBED_TERMINATOR_EN
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EMBED, S_TERM, S_PASS} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMBED, S_PASS} state_t;
`endif
endpackage

// File: rtl/lsb_bit_serializer.sv
// lsb_bit_serializer: holds the current message byte and yields its bits MSB-first, one per accepted pixel
module lsb_bit_serializer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_load,
   input  logic [7:0] i_byte,
   input  logic       i_last,
   input  logic       i_shift,
   output logic       o_bit,
   output logic       o_idx_zero,
   output logic       o_last
);
   logic [7:0] r_byte;
   logic [2:0] r_idx;
   logic       r_last;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_byte <= '0;
         r_idx  <= '0;
         r_last <= 1'b0;
      end else if (i_load) begin
         r_byte <= i_byte;
         r_idx  <= 3'd7;
         r_last <= i_last;
      end else if (i_shift) begin
         r_idx  <= r_idx - 3'd1;
      end
   assign o_bit      = r_byte[r_idx];
   assign o_idx_zero = (r_idx == 3'd0);
   assign o_last     = r_last;
endmodule

// File: rtl/lsb_embed.sv
// lsb_embed: embeds a message byte stream MSB-first into cover pixel LSBs, one bit per pixel
// LSB_EMBED_TERMINATOR_EN appends a 0x00 terminator byte after the final message byte
module lsb_embed
   import lsb_stego_pkg::*;
#(
   parameter int PIXEL_W      = PIXEL_W_DEF,
   parameter int FRAME_PIXELS = FRAME_PIXELS_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               pix_in_valid,
   output logic               pix_in_ready,
   input  logic [PIXEL_W-1:0] pix_in_data,
   input  logic               msg_valid,
   output logic               msg_ready,
   input  logic [7:0]         msg_data,
   input  logic               msg_last,
   output logic               pix_out_valid,
   input  logic               pix_out_ready,
   output logic [PIXEL_W-1:0] pix_out_data,
   output logic               busy,
   output logic               done,
   output logic               overflow
);
   localparam int               CNT_W    = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

   state_t               r_state, w_state_seq, w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_out_valid, r_done, r_ovf;
   logic [PIXEL_W-1:0]   r_out_data;
   logic                 w_embed, w_accept, w_msg_acc, w_frame_end, w_byte_done;
   logic                 w_bit, w_idx_zero, w_last, w_load, w_load_last;
   logic [7:0]           w_load_byte;

`ifdef LSB_EMBED_TERMINATOR_EN
   localparam state_t S_AFTER_MSG = S_TERM;
   assign w_embed     = (r_state == S_EMBED) || (r_state == S_TERM);
   // the terminator is loaded as a final byte the moment the last message bit goes out
   assign w_load      = w_msg_acc || ((r_state == S_EMBED) && w_byte_done && w_last);
   assign w_load_byte = w_msg_acc ? msg_data : TERM_BYTE;
   assign w_load_last = w_msg_acc ? msg_last : 1'b1;
`else
   localparam state_t S_AFTER_MSG = S_PASS;
   assign w_embed     = (r_state == S_EMBED);
   assign w_load      = w_msg_acc;
   assign w_load_byte = msg_data;
   assign w_load_last = msg_last;
`endif

   assign pix_in_ready  = (w_embed || (r_state == S_PASS)) && (!r_out_valid || pix_out_ready);
   assign msg_ready     = (r_state == S_FETCH);
   assign busy          = (r_state != S_IDLE);
   assign done          = r_done;
   assign overflow      = r_ovf;
   assign pix_out_valid = r_out_valid;
   assign pix_out_data  = r_out_data;

   assign w_accept    = pix_in_valid && pix_in_ready;
   assign w_msg_acc   = msg_valid && msg_ready;
   assign w_frame_end = w_accept && (r_cnt == LAST_PIX);
   assign w_byte_done = w_accept && w_embed && w_idx_zero;

   lsb_bit_serializer u_ser (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_byte     (w_load_byte),
      .i_last     (w_load_last),
      .i_shift    (w_accept && w_embed),
      .o_bit      (w_bit),
      .o_idx_zero (w_idx_zero),
      .o_last     (w_last)
   );

   always_comb begin
      w_state_seq = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_seq = S_FETCH;
         S_FETCH: if (w_msg_acc) w_state_seq = S_EMBED;
         S_EMBED: if (w_byte_done) w_state_seq = w_last ? S_AFTER_MSG : S_FETCH;
`ifdef LSB_EMBED_TERMINATOR_EN
         S_TERM:  if (w_byte_done) w_state_seq = S_PASS;
`endif
         default: ;
      endcase
      w_state_nxt = w_frame_end ? S_IDLE : w_state_seq;
   end

   // the frame ends cleanly only if the message (and terminator) would have reached PASS
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_done      <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_frame_end;
         if ((r_state == S_IDLE) && start) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
         end else if (w_accept) begin
            r_cnt <= w_frame_end ? '0 : r_cnt + CNT_W'(1);
            if (w_frame_end && (w_state_seq != S_PASS)) r_ovf <= 1'b1;
         end
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_embed ? {pix_in_data[PIXEL_W-1:1], w_bit} : pix_in_data;
         end else if (pix_out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
endmodule

// File: doc/lsb_embed.md
LSB_EMBED -- requirements
Module: lsb_embed

Interface
REQ-001 SHALL have parameter PIXEL_W, default 16: cover/stego pixel width.
REQ-002 SHALL have parameter FRAME_PIXELS, default 41420: pixels per image frame.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: one-cycle pulse, begins a frame; ignored unless IDLE.
REQ-006 SHALL have ports pix_in_valid (input, 1), pix_in_ready (output, 1), pix_in_data (input, PIXEL_W): cover pixel stream.
REQ-007 SHALL have ports msg_valid (input, 1), msg_ready (output, 1), msg_data (input, 8), msg_last (input, 1): message byte stream; msg_last marks the final byte.
REQ-008 SHALL have ports pix_out_valid (output, 1), pix_out_ready (input, 1), pix_out_data (output, PIXEL_W): stego pixel stream.
REQ-009 SHALL have outputs busy (1), done (1, one-cycle pulse), overflow (1, sticky).

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, EMBED, PASS (plus TERM, see Configuration).
REQ-011 IDLE: pix_in_ready=0, msg_ready=0, busy=0; start -> FETCH, clear pixel counter and overflow.
REQ-012 FETCH: msg_ready=1, pix_in_ready=0; on msg handshake latch byte and msg_last -> EMBED, bit index 7.
REQ-013 EMBED: each accepted pixel outputs {pix_in_data[PIXEL_W-1:1], current bit}; bits MSB-first; bit index decrements per accepted pixel.
REQ-014 After bit 0 is embedded: latched last=0 -> FETCH; last=1 -> PASS (or TERM when enabled).
REQ-015 PASS: pixels forwarded unmodified; msg_ready=0.
REQ-016 Pixel acceptance SHALL be pix_in_valid && pix_in_ready; pix_in_ready = state in {EMBED,TERM,PASS} && (!pix_out_valid || pix_out_ready).
REQ-017 Output SHALL be a single register stage: latency 1 cycle from input handshake to pix_out_valid; data held stable while pix_out_valid && !pix_out_ready.
REQ-018 Pixel counter SHALL count accepted pixels 0..FRAME_PIXELS-1; acceptance of pixel FRAME_PIXELS-1 -> IDLE with done pulse in the following cycle, from any state.
REQ-019 Frame ending in FETCH/EMBED/TERM (message not fully embedded) SHALL set overflow=1; remaining message bytes are not consumed.
REQ-020 Message completing exactly on the last frame pixel SHALL NOT set overflow.
REQ-021 busy SHALL be 1 in every non-IDLE state.
REQ-022 start while non-IDLE SHALL be ignored.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, counters 0, pix_out_valid=0, pix_out_data=0, done=0, overflow=0, busy=0, ready outputs 0; an in-flight frame is abandoned.

Configuration
REQ-024 Macro LSB_EMBED_TERMINATOR_EN defined: after the msg_last byte, state TERM embeds eight 0 bits (byte 0x00) in the next 8 pixels, then PASS; terminator not fitting in the frame sets overflow.
REQ-025 Macro undefined: TERM absent; EMBED goes directly to PASS after the last byte.

Structure
REQ-026 Package lsb_stego_pkg SHALL hold PIXEL_W and FRAME_PIXELS defaults, the FSM state enum, and the terminator byte constant.
REQ-027 Sub-module lsb_bit_serializer SHALL hold byte register, bit index and last flag, advancing one bit per accepted pixel.

Verification
REQ-028 Byte 0xA5 last, 16 pixels 0xFFFF -> outputs FFFF,FFFE,FFFF,FFFE,FFFE,FFFF,FFFE,FFFF, then 8x FFFF; done after 16th (FRAME_PIXELS=16).
REQ-029 pix_out_ready low 5 cycles mid-EMBED -> pix_out_data stable, pix_in_ready=0, no pixel or bit lost.
REQ-030 FRAME_PIXELS=8, two message bytes -> overflow=1, done pulse, second byte never handshaken.
REQ-031 msg_valid delayed 10 cycles in FETCH -> no pixel accepted meanwhile, embedding resumes at bit 7 of new byte.
REQ-032 rst_n asserted mid-EMBED -> all outputs zero immediately; new start embeds from a fresh message byte.
REQ-033 With LSB_EMBED_TERMINATOR_EN, byte 0x01 last, pixels 0x0003 -> LSBs 00000001 then 00000000, then pass-through.
